// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
// Module   : game_timer
// Brief    : Round countdown timer with tick prescaler, run/pause/expire FSM,
//            runtime reload and low-time warning. Optional BCD count outputs
//            are enabled by defining GAME_TIMER_BCD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module game_timer #(
  parameter int INIT_COUNT = 60,
  parameter int MAX_COUNT  = 99,
  parameter int TICK_DIV   = 50_000_000,
  parameter int WARN_AT    = 10,
  localparam int W         = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         pause,
  input  logic         restart,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         running,
  output logic         warn,
  output logic         done,
  output logic         expired
`ifdef GAME_TIMER_BCD_EN
  ,
  output logic [3:0]   bcd_tens,
  output logic [3:0]   bcd_ones
`endif
);

  localparam int             c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PW-1:0] c_TICK_LAST = c_PW'(TICK_DIV - 1);
  localparam logic [W-1:0]   c_INIT      = W'(INIT_COUNT);
  localparam logic [W-1:0]   c_MAX       = W'(MAX_COUNT);
  // count never exceeds MAX_COUNT, so clamping the threshold keeps it in range
  localparam logic [W-1:0]   c_WARN      = (WARN_AT > MAX_COUNT) ? c_MAX : W'(WARN_AT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [W-1:0]    r_count;
  logic [W-1:0]    w_count_nx;
  logic [c_PW-1:0] r_presc;
  logic [c_PW-1:0] w_presc_nx;
  logic            r_running;
  logic            r_warn;
  logic            r_done;
  logic            r_expired;
  logic            w_done_nx;
  logic            w_warn_nx;
  logic [W-1:0]    w_load_clamped;

  assign w_load_clamped = (load_val > c_MAX) ? c_MAX : load_val;

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_presc_nx = r_presc;
    w_done_nx  = 1'b0;
    if (restart) begin
      w_state_nx = S_IDLE;
      w_count_nx = c_INIT;
      w_presc_nx = '0;
    end else if (load_en) begin
      w_state_nx = S_IDLE;
      w_count_nx = w_load_clamped;
      w_presc_nx = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !pause && (r_count != '0)) begin
            w_state_nx = S_RUN;
          end
        end
        S_RUN: begin
          if (pause || !start) begin
            w_state_nx = S_PAUSED;
          end else if (r_presc == c_TICK_LAST) begin
            w_presc_nx = '0;
            if (r_count != '0) begin
              w_count_nx = r_count - W'(1);
            end
            if (r_count <= W'(1)) begin
              w_count_nx = '0;
              w_state_nx = S_EXPIRED;
              w_done_nx  = 1'b1;
            end
          end else begin
            w_presc_nx = r_presc + c_PW'(1);
          end
        end
        S_PAUSED: begin
          if (!pause && start) begin
            w_state_nx = S_RUN;
          end
        end
        S_EXPIRED: begin
          w_count_nx = '0;
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  assign w_warn_nx = ((w_state_nx == S_RUN) || (w_state_nx == S_PAUSED)) &&
                     (w_count_nx <= c_WARN) && (w_count_nx != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_count   <= c_INIT;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_warn    <= 1'b0;
      r_done    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_count   <= w_count_nx;
      r_presc   <= w_presc_nx;
      r_running <= (w_state_nx == S_RUN);
      r_warn    <= w_warn_nx;
      r_done    <= w_done_nx;
      r_expired <= (w_state_nx == S_EXPIRED);
    end
  end

  assign count   = r_count;
  assign running = r_running;
  assign warn    = r_warn;
  assign done    = r_done;
  assign expired = r_expired;

`ifdef GAME_TIMER_BCD_EN
  if (MAX_COUNT > 99) begin : g_bcd_range_check
    $error("game_timer: BCD outputs need MAX_COUNT <= 99");
  end

  logic [3:0] r_bcd_tens;
  logic [3:0] r_bcd_ones;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd_tens <= 4'(INIT_COUNT / 10);
      r_bcd_ones <= 4'(INIT_COUNT % 10);
    end else begin
      r_bcd_tens <= 4'(int'(w_count_nx) / 10);
      r_bcd_ones <= 4'(int'(w_count_nx) % 10);
    end
  end

  assign bcd_tens = r_bcd_tens;
  assign bcd_ones = r_bcd_ones;
`endif

endmodule
`default_nettype wire

// File: doc/game_timer.md
# game_timer

Parametrised countdown timer for the whack-a-mole round clock. It succeeds the fixed 60-second down-counter and adds an internal tick prescaler, a run/pause/expire state machine, runtime reload and a low-time warning. The single counter is replaced by a configurable-width counter with a one-cycle `done` pulse. It sits between the game controller (start/pause/load) and the score/display logic (count, warn, expired).

## Interface
- `INIT_COUNT`, default 60: count loaded at reset and on `restart`.
- `MAX_COUNT`, default 99: largest loadable count; sets `W = $clog2(MAX_COUNT+1)`.
- `TICK_DIV`, default 50_000_000: `clk` cycles per count step (≥1).
- `WARN_AT`, default 10: `warn` is asserted while running and `count <= WARN_AT`.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: level; begin or resume counting.
- `pause` input, 1 bit: level; freeze counting while high.
- `restart` input, 1 bit: pulse; reload `INIT_COUNT`, go to IDLE.
- `load_en` input, 1 bit: pulse; load `load_val`, go to IDLE.
- `load_val` input, W bits: reload value, saturated to `MAX_COUNT`.
- `count` output, W bits: current remaining count.
- `running` output, 1 bit: high in RUN state.
- `warn` output, 1 bit: low-time indicator.
- `done` output, 1 bit: one-cycle pulse on the transition to 0.
- `expired` output, 1 bit: level, high in EXPIRED state.

## Operation
- States:
  - IDLE: reset state.
  - RUN
  - PAUSED
  - EXPIRED
- Priority per cycle: `restart` > `load_en` > `pause` > `start`.
- `restart` or `load_en`:
  - Any state goes to IDLE and the prescaler clears to 0.
  - `count` takes `INIT_COUNT` or `min(load_val, MAX_COUNT)` respectively.
- IDLE → RUN when `start`=1, `pause`=0 and `count`≠0. With `count`=0, `start` is ignored: no `done`, no EXPIRED.
- RUN:
  - Prescaler increments each cycle and wraps at `TICK_DIV-1`; the wrap cycle is a tick.
  - On a tick, `count` decrements by 1.
  - A tick with `count`=1 → `count`=0, `done`=1 for that cycle, state EXPIRED.
- RUN → PAUSED when `pause`=1 or `start`=0. The prescaler holds its value and no tick occurs that cycle.
- PAUSED → RUN when `pause`=0 and `start`=1. The prescaler resumes from its held value.
- EXPIRED holds `count`=0 and ignores `start`/`pause`. Only `restart`/`load_en` leave it.
- Arithmetic:
  - `count` never underflows or wraps.
  - Loaded values above `MAX_COUNT` clamp to `MAX_COUNT`.
- `warn` = RUN or PAUSED, and `count`≤`WARN_AT`, and `count`≠0.

## Timing
- Reset values (`rst`=0, immediate):
  - state IDLE
  - `count`=`INIT_COUNT`
  - prescaler 0
  - `running`=0, `warn`=0, `done`=0, `expired`=0
- All outputs are registered; there are no combinational input→output paths.
- Entering RUN at edge E puts the first decrement at edge E+`TICK_DIV` and later decrements every `TICK_DIV` cycles. With `TICK_DIV`=1, `count` decrements every cycle while RUN.
- `done` and `expired` rise on the same edge that `count` becomes 0. `done` falls on the next edge.
- `restart`/`load_en` take effect on the next edge and cancel a tick due that cycle: the load wins and no `done` is issued.
- Reset asserted mid-count aborts immediately with no `done`. Release is synchronised to `clk` by the surrounding reset logic.

## Configuration
- `GAME_TIMER_BCD_EN` defined:
  - Adds outputs `bcd_tens` [3:0] and `bcd_ones` [3:0], registered and updated on the same edge as `count`.
  - Requires `MAX_COUNT`≤99; elaboration fails with `$error` otherwise.
  - Reset value is the BCD of `INIT_COUNT`.
- Undefined: the BCD ports and logic are absent; the binary `count` is the only count output.

## Test plan
- Parameters `INIT_COUNT`=5, `TICK_DIV`=4, `WARN_AT`=2.
  - Stimulus: release reset, hold `start`=1.
  - Required: `count` steps 5,4,3,2,1,0 with steps 4 cycles apart, the first 4 cycles after RUN entry.
  - Required: `warn` high from `count`=2 until `count` reaches 0.
  - Required: `done` high exactly one cycle, coincident with `count`=0. `expired`=1 thereafter and `count` stays 0.
- Pause mid-count:
  - Stimulus: assert `pause` 2 cycles after a tick with `count`=3; hold 10 cycles; release.
  - Required: `count` stays 3 and `running`=0 while paused.
  - Required: next decrement 2 cycles after release.
- Load clamp:
  - Stimulus: `load_val`=120 with `MAX_COUNT`=99 and `load_en` pulse.
  - Required: `count`=99, state IDLE.
  - Stimulus: `load_val`=0 then `start`.
  - Required: stays IDLE, no `done`.
- Simultaneous events:
  - Stimulus: `restart` in the same cycle as a tick from `count`=1.
  - Required: `count`=5, IDLE, `done` never asserts.
  - Stimulus: `load_en` and `restart` together.
  - Required: `count`=`INIT_COUNT`.
- Reset mid-operation:
  - Stimulus: `rst` low at `count`=3 in RUN.
  - Required: `count`=5 and all flags 0 immediately, without a clock edge.
- `GAME_TIMER_BCD_EN`:
  - Stimulus: `INIT_COUNT`=60, count down to 59.
  - Required: `bcd_tens`/`bcd_ones` go 6/0 → 5/9 on the same edge as `count`.
